ipv4_tx: RTL and testbench
==========================

Name: ipv4_tx

Overview:
- Transmit counterpart of the IPv4 RX filter. Sits between transport (UDP TX) and MAC TX.
- On a transport packet start, it emits a 20-byte IPv4 header with no options, then passes the payload through. The header carries a computed total length, an incrementing identification and the header checksum.
- 16-bit datapath only. The first wire byte of each beat is in data[7:0].

Parameters:
- DATA_W, 16, datapath width; only 16 is supported.
- SRC_ADDR, {8'd206,8'd200,8'd127,8'd128}, IPv4 source address.
- DST_ADDR, {8'd206,8'd200,8'd127,8'd128}, IPv4 destination address.
- PROTOCOL, 8'd17, protocol field (UDP).
- TTL, 8'd64, time to live.
- TOS, 8'd0, DSCP/ECN byte.

Ports:
- clk  in  1  clock.
- nreset  in  1  synchronous, active-low reset.
- cancel_i  in  1  transport abort of the current packet.
- valid_i  in  1  transport beat valid.
- start_i  in  1  first payload beat.
- data_i  in  16  payload data.
- len_i  in  2  valid bytes in beat (1 or 2).
- pl_len_i  in  16  payload byte count; valid and stable while start_i&valid_i.
- ready_o  out  1  transport beat accepted when valid_i&ready_o.
- ready_i  in  1  MAC accepts beat when valid_o&ready_i.
- valid_o  out  1  beat valid to MAC.
- start_o  out  1  first header beat.
- term_o  out  1  last payload beat.
- cancel_o  out  1  abort to MAC.
- len_err_o  out  1  one-cycle pulse: illegal pl_len_i.
- data_o  out  16  beat data.
- len_o  out  2  valid bytes in beat.

Behaviour:
- Reset state: FSM=IDLE, id_q=0.
- Outputs under reset and in IDLE: valid_o, start_o, term_o, cancel_o, len_err_o and ready_o are 0.
- FSM states: IDLE, HEAD, DATA, DROP.
- IDLE→HEAD on valid_i&start_i&legal length.
  - Legal length is 1 ≤ pl_len_i ≤ 65515.
  - The start beat is not consumed; ready_o=0 in IDLE.
  - Latched on this transition: tot_len_q=pl_len_i+20, rem_q=pl_len_i, cs_q, id_q captured into hdr_id_q.
  - id_q increments on this transition and wraps 0xFFFF→0.
- IDLE→DROP on valid_i&start_i&illegal length.
  - len_err_o pulses in that cycle.
  - DROP: ready_o=1, valid_o=0; consumes beats until rem reaches 0 (rem=max(pl_len_i,1)), then returns to IDLE.
- Checksum (cs_q):
  - 16-bit one's-complement sum of the nine non-checksum header words, with end-around carry folded twice, then inverted.
  - The constant words are summed by parameter elaboration; tot_len and id are added in logic.
  - Registered, so the first header beat appears the cycle after start is seen.
- HEAD: 10 beats, word counter hw 0..9.
  - Word values (big-endian), in order: {4'h4,4'h5,TOS}, tot_len, id, 16'h4000 (DF set, offset 0), {TTL,PROTOCOL}, checksum, SRC[31:16], SRC[15:0], DST[31:16], DST[15:0].
  - data_o = {word[7:0],word[15:8]}; len_o=2; valid_o=1; ready_o=0.
  - hw advances only on ready_i; start_o=1 while hw==0.
  - hw==9 & ready_i → DATA.
- DATA: pass-through.
  - valid_o=valid_i, ready_o=ready_i, data_o=data_i.
  - len_o = (rem_q==1) ? 1 : 2.
  - On each transfer rem_q -= len_o.
  - term_o = valid_i & (rem_q ≤ 2).
  - A transfer with term_o → IDLE; the next start is accepted no earlier than the following cycle.
  - len_i shorter than 2 on a non-final beat is a transport protocol error; the byte count still uses len_o.
- MAC backpressure: while ready_i=0, all outputs hold stable (valid_o, data_o, start_o, term_o, len_o).
- cancel_i:
  - In HEAD/DATA/DROP: cancel_o=1 the same cycle, FSM→IDLE next cycle, id_q not rolled back.
  - In IDLE: cancel_o=0 and the request is ignored.
  - cancel_i has priority over a simultaneous term transfer.
- nreset low mid-packet: FSM→IDLE and id_q→0 next edge; outputs deasserted from that edge.

Test Plan:
- pl_len_i=8, id_q=0, ready_i=1 → 10 header beats, then 4 payload beats.
  - Header beats: 0x0045, 0x1C00, 0x0000, 0x0040, 0x1140, 0x3F9E, 0xC8CE, 0x807F, 0xC8CE, 0x807F.
  - start_o on beat 0; term_o on the 4th payload beat.
  - Following packet carries id word 0x0100.
- pl_len_i=3 → tot_len word 0x1700; payload beats have len_o 2 then 1; term_o on the second beat, then IDLE.
- ready_i toggled 0/1 randomly during header and payload → no beat lost or duplicated; data_o/valid_o stable while ready_i=0; ready_o=0 throughout HEAD.
- cancel_i at hw==4 → cancel_o=1 same cycle; next packet starts a fresh header with id incremented by 1 relative to the cancelled one.
- pl_len_i=0 and pl_len_i=65516 → len_err_o one-cycle pulse; valid_o stays 0; transport beats drained with ready_o=1; returns to IDLE.
- Identification wrap: 65536 back-to-back 1-byte packets → id field returns to 0x0000; checksum matches reference sum on every packet.

Source files
------------

// File: rtl/ipv4_tx.sv
// IPv4 transmit framer: prepends a 20-byte option-less IPv4 header to each
// transport packet and then passes the payload through to the MAC.
// Wire order is little-end-first within a beat: first byte in data[7:0].
//
// state | meaning
// IDLE  | waiting for a transport start beat (start beat is not consumed here)
// HEAD  | emitting the 10 header words, hw_q = 0..9
// DATA  | payload pass-through until the term beat
// DROP  | illegal payload length: swallow the transport beats
module ipv4_tx #(
   parameter int          DATA_W   = 16,
   parameter logic [31:0] SRC_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
   parameter logic [31:0] DST_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
   parameter logic [7:0]  PROTOCOL = 8'd17,
   parameter logic [7:0]  TTL      = 8'd64,
   parameter logic [7:0]  TOS      = 8'd0
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              cancel_i,
   input  logic              valid_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        len_i,
   input  logic [15:0]       pl_len_i,
   output logic              ready_o,
   input  logic              ready_i,
   output logic              valid_o,
   output logic              start_o,
   output logic              term_o,
   output logic              cancel_o,
   output logic              len_err_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        len_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HEAD = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   localparam logic [15:0] HDR_LEN    = 16'd20;
   localparam logic [15:0] MAX_PL_LEN = 16'd65515;

   localparam logic [15:0] W_VER_TOS   = {4'h4, 4'h5, TOS};
   localparam logic [15:0] W_FLAGS     = 16'h4000;
   localparam logic [15:0] W_TTL_PROTO = {TTL, PROTOCOL};

   // Everything but tot_len and id is fixed at elaboration.
   localparam logic [31:0] CONST_SUM = 32'(W_VER_TOS) + 32'(W_FLAGS) + 32'(W_TTL_PROTO)
                                     + 32'(SRC_ADDR[31:16]) + 32'(SRC_ADDR[15:0])
                                     + 32'(DST_ADDR[31:16]) + 32'(DST_ADDR[15:0]);

   logic [1:0]  state_q;
   logic [3:0]  hw_q;
   logic [15:0] rem_q;
   logic [15:0] tot_len_q;
   logic [15:0] hdr_id_q;
   logic [15:0] id_q;
   logic [15:0] cs_q;

   logic        start_seen;
   logic        len_legal;
   logic        rem_last;
   logic [15:0] step;
   logic [15:0] tot_len_d;
   logic [31:0] cs_sum;
   logic [16:0] cs_f1;
   logic [15:0] cs_f2;
   logic [15:0] cs_d;
   logic [15:0] hdr_word;

   assign start_seen = valid_i & start_i;
   assign len_legal  = (pl_len_i != 16'd0) && (pl_len_i <= MAX_PL_LEN);
   assign tot_len_d  = pl_len_i + HDR_LEN;
   assign rem_last   = (rem_q <= 16'd2);
   assign step       = (rem_q == 16'd1) ? 16'd1 : 16'd2;

   // The sum is at most a few bits over 16, so two end-around folds always settle it.
   assign cs_sum = CONST_SUM + {16'd0, tot_len_d} + {16'd0, id_q};
   assign cs_f1  = {1'b0, cs_sum[15:0]} + {1'b0, cs_sum[31:16]};
   assign cs_f2  = cs_f1[15:0] + {15'd0, cs_f1[16]};
   assign cs_d   = ~cs_f2;

   // Header word selected by the word counter, big-endian field order.
   always_comb begin
      hdr_word = W_VER_TOS;
      case (hw_q)
         4'd0:    hdr_word = W_VER_TOS;
         4'd1:    hdr_word = tot_len_q;
         4'd2:    hdr_word = hdr_id_q;
         4'd3:    hdr_word = W_FLAGS;
         4'd4:    hdr_word = W_TTL_PROTO;
         4'd5:    hdr_word = cs_q;
         4'd6:    hdr_word = SRC_ADDR[31:16];
         4'd7:    hdr_word = SRC_ADDR[15:0];
         4'd8:    hdr_word = DST_ADDR[31:16];
         default: hdr_word = DST_ADDR[15:0];
      endcase
   end

   // Packet sequencing, header latching and payload byte accounting.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q   <= ST_IDLE;
         hw_q      <= 4'd0;
         rem_q     <= 16'd0;
         tot_len_q <= 16'd0;
         hdr_id_q  <= 16'd0;
         id_q      <= 16'd0;
         cs_q      <= 16'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_seen) begin
                  if (len_legal) begin
                     state_q   <= ST_HEAD;
                     hw_q      <= 4'd0;
                     rem_q     <= pl_len_i;
                     tot_len_q <= tot_len_d;
                     cs_q      <= cs_d;
                     hdr_id_q  <= id_q;
                     id_q      <= id_q + 16'd1;
                  end else begin
                     state_q <= ST_DROP;
                     rem_q   <= (pl_len_i == 16'd0) ? 16'd1 : pl_len_i;
                  end
               end
            end
            ST_HEAD: begin
               if (cancel_i) begin
                  state_q <= ST_IDLE;
               end else if (ready_i) begin
                  if (hw_q == 4'd9) begin
                     state_q <= ST_DATA;
                  end else begin
                     hw_q <= hw_q + 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (cancel_i) begin
                  state_q <= ST_IDLE;
               end else if (valid_i && ready_i) begin
                  rem_q <= rem_q - step;
                  if (rem_last) begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               if (cancel_i) begin
                  state_q <= ST_IDLE;
               end else if (valid_i) begin
                  rem_q <= rem_q - step;
                  if (rem_last) begin
                     state_q <= ST_IDLE;
                  end
               end
            end
         endcase
      end
   end

   // Output decode; everything is forced quiet while reset is held.
   always_comb begin
      valid_o   = 1'b0;
      start_o   = 1'b0;
      term_o    = 1'b0;
      cancel_o  = 1'b0;
      len_err_o = 1'b0;
      ready_o   = 1'b0;
      data_o    = '0;
      len_o     = 2'd0;
      if (nreset) begin
         case (state_q)
            ST_IDLE: begin
               len_err_o = start_seen & ~len_legal;
            end
            ST_HEAD: begin
               valid_o  = 1'b1;
               start_o  = (hw_q == 4'd0);
               data_o   = {hdr_word[7:0], hdr_word[15:8]};
               len_o    = 2'd2;
               cancel_o = cancel_i;
            end
            ST_DATA: begin
               valid_o  = valid_i;
               ready_o  = ready_i;
               data_o   = data_i;
               len_o    = (rem_q == 16'd1) ? 2'd1 : 2'd2;
               term_o   = valid_i & rem_last;
               cancel_o = cancel_i;
            end
            default: begin
               ready_o  = 1'b1;
               cancel_o = cancel_i;
            end
         endcase
      end
   end

   // A short transport beat is only meaningful as the final payload beat.
   always_ff @(posedge clk) begin
      if (nreset && state_q == ST_DATA && valid_i && ready_i && !cancel_i && !rem_last)
         assert (len_i == 2'd2);
   end

endmodule

// File: tb/tb_ipv4_tx.sv
// Bench for ipv4_tx: transaction-level model of the expected MAC beat stream
// plus per-cycle checks of handshake/idle behaviour.
module tb_ipv4_tx;

   logic        clk      = 1'b0;
   logic        nreset   = 1'b0;
   logic        cancel_i = 1'b0;
   logic        valid_i  = 1'b0;
   logic        start_i  = 1'b0;
   logic [15:0] data_i   = 16'd0;
   logic [1:0]  len_i    = 2'd0;
   logic [15:0] pl_len_i = 16'd0;
   logic        ready_i  = 1'b0;
   logic        ready_o, valid_o, start_o, term_o, cancel_o, len_err_o;
   logic [15:0] data_o;
   logic [1:0]  len_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        hdr;
      logic [15:0] d;
      logic [1:0]  l;
      logic        s;
      logic        t;
   } beat_t;

   beat_t exp_q[$];
   beat_t cap_q[$];
   int    m_mode  = 0;   // 0 idle, 1 packet, 2 drop
   int    m_id    = 0;
   bit    capture = 1'b0;
   bit    rnd     = 1'b0;

   logic [15:0] lits[10];

   always #5 clk = ~clk;

   ipv4_tx dut (
      .clk(clk), .nreset(nreset), .cancel_i(cancel_i), .valid_i(valid_i),
      .start_i(start_i), .data_i(data_i), .len_i(len_i), .pl_len_i(pl_len_i),
      .ready_o(ready_o), .ready_i(ready_i), .valid_o(valid_o), .start_o(start_o),
      .term_o(term_o), .cancel_o(cancel_o), .len_err_o(len_err_o),
      .data_o(data_o), .len_o(len_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference header: plain sum over the ten words with checksum field zero.
   function automatic int cksum(input int tot, input int id);
      int s;
      s = 'h4500 + tot + id + 'h4000 + 'h4011 + 'hcec8 + 'h7f80 + 'hcec8 + 'h7f80;
      while (s > 'hffff) s = (s & 'hffff) + (s >> 16);
      return (~s) & 'hffff;
   endfunction

   function automatic int hdr_word(input int tot, input int id, input int i);
      case (i)
         0: return 'h4500;
         1: return tot;
         2: return id;
         3: return 'h4000;
         4: return 'h4011;
         5: return cksum(tot, id);
         6: return 'hcec8;
         7: return 'h7f80;
         8: return 'hcec8;
         default: return 'h7f80;
      endcase
   endfunction

   function automatic logic [15:0] wire16(input int w);
      return 16'(((w & 'hff) << 8) | ((w >> 8) & 'hff));
   endfunction

   function automatic int beat_len(input int len, input int k);
      return (len - 2 * k >= 2) ? 2 : 1;
   endfunction

   task automatic push_exp(input int len, input logic [15:0] pd[$]);
      beat_t e;
      int    nb;
      nb = (len + 1) / 2;
      for (int i = 0; i < 10; i++) begin
         e.hdr = 1'b1;
         e.d   = wire16(hdr_word(len + 20, m_id, i));
         e.l   = 2'd2;
         e.s   = (i == 0);
         e.t   = 1'b0;
         exp_q.push_back(e);
      end
      for (int k = 0; k < nb; k++) begin
         e.hdr = 1'b0;
         e.d   = pd[k];
         e.l   = 2'(beat_len(len, k));
         e.s   = 1'b0;
         e.t   = (k == nb - 1);
         exp_q.push_back(e);
      end
   endtask

   // MAC-side ready: random when rnd is set, otherwise always ready.
   always @(posedge clk) begin
      #1;
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Per-cycle compare against the model, sampled mid-cycle.
   logic        p_hold = 1'b0;
   int          p_mode = 0;
   logic [15:0] p_d;
   logic [1:0]  p_l;
   logic        p_s, p_t;
   always @(negedge clk) begin
      beat_t e;
      beat_t c;
      if (nreset) begin
         if (p_hold && m_mode == p_mode) begin
            chk("hold_valid", valid_o, 1);
            chk("hold_data", data_o, p_d);
            chk("hold_len", len_o, p_l);
            chk("hold_start", start_o, p_s);
            chk("hold_term", term_o, p_t);
         end
         if (m_mode == 0) begin
            chk("idle_valid", valid_o, 0);
            chk("idle_ready", ready_o, 0);
            chk("idle_cancel", cancel_o, 0);
            chk("idle_len_err", len_err_o,
                valid_i & start_i & (pl_len_i == 16'd0 || pl_len_i > 16'd65515));
         end else if (m_mode == 2) begin
            chk("drop_valid", valid_o, 0);
            chk("drop_ready", ready_o, 1);
            chk("drop_len_err", len_err_o, 0);
         end else if (exp_q.size() > 0 && exp_q[0].hdr) begin
            chk("head_valid", valid_o, 1);
            chk("head_ready", ready_o, 0);
         end else begin
            chk("data_valid", valid_o, valid_i);
            chk("data_ready", ready_o, ready_i);
         end
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", data_o, e.d);
               chk("beat_len", len_o, e.l);
               chk("beat_start", start_o, e.s);
               chk("beat_term", term_o, e.t);
               if (capture) begin
                  c.hdr = e.hdr; c.d = data_o; c.l = len_o; c.s = start_o; c.t = term_o;
                  cap_q.push_back(c);
               end
            end
         end
      end
      p_hold = nreset & valid_o & ~ready_i & ~cancel_i;
      p_mode = m_mode;
      p_d = data_o; p_l = len_o; p_s = start_o; p_t = term_o;
   end

   task automatic wait_accept();
      int   n;
      logic acc;
      n = 0;
      while (1) begin
         @(negedge clk);
         acc = ready_o & valid_i;
         @(posedge clk); #1;
         if (acc) break;
         n++;
         if (n > 500) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic do_reset();
      nreset = 1'b0; valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("rst_valid", valid_o, 0);
      chk("rst_start", start_o, 0);
      chk("rst_term", term_o, 0);
      chk("rst_cancel", cancel_o, 0);
      chk("rst_len_err", len_err_o, 0);
      chk("rst_ready", ready_o, 0);
      @(posedge clk); #1;
      nreset = 1'b1;
      exp_q.delete();
      m_id = 0;
      m_mode = 0;
   endtask

   task automatic begin_pkt(input int len, output logic [15:0] pd[$]);
      int nb;
      nb = (len + 1) / 2;
      pd.delete();
      for (int k = 0; k < nb; k++) pd.push_back(16'($urandom));
      valid_i = 1'b1; start_i = 1'b1; pl_len_i = 16'(len);
      data_i = pd[0]; len_i = 2'(beat_len(len, 0));
      @(posedge clk); #1;
      push_exp(len, pd);
      m_id = (m_id + 1) & 'hffff;
      m_mode = 1;
   endtask

   task automatic send_pkt(input int len, input bit gaps);
      logic [15:0] pd[$];
      int          nb;
      nb = (len + 1) / 2;
      begin_pkt(len, pd);
      for (int k = 0; k < nb; k++) begin
         if (k > 0) begin
            valid_i = 1'b0; start_i = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            valid_i = 1'b1; data_i = pd[k]; len_i = 2'(beat_len(len, k));
         end
         wait_accept();
      end
      valid_i = 1'b0; start_i = 1'b0; m_mode = 0;
      chk("pkt_drained", exp_q.size(), 0);
   endtask

   task automatic cancel_at(input int len, input int at);
      logic [15:0] pd[$];
      begin_pkt(len, pd);
      repeat (at) begin @(posedge clk); #1; end
      cancel_i = 1'b1;
      @(negedge clk);
      chk("cancel_o", cancel_o, 1);
      @(posedge clk); #1;
      cancel_i = 1'b0; valid_i = 1'b0; start_i = 1'b0;
      exp_q.delete();
      m_mode = 0;
   endtask

   task automatic send_drop(input int len);
      int nb;
      nb = ((len == 0 ? 1 : len) + 1) / 2;
      valid_i = 1'b1; start_i = 1'b1; pl_len_i = 16'(len);
      data_i = 16'($urandom); len_i = 2'd2;
      @(negedge clk);
      chk("drop_pulse", len_err_o, 1);
      @(posedge clk); #1;
      m_mode = 2;
      for (int k = 0; k < nb; k++) begin
         if (k > 0) begin start_i = 1'b0; data_i = 16'($urandom); end
         wait_accept();
      end
      valid_i = 1'b0; start_i = 1'b0; m_mode = 0;
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: run did not complete, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      lits = '{16'h0045, 16'h1C00, 16'h0000, 16'h0040, 16'h1140,
               16'h3F9E, 16'hC8CE, 16'h807F, 16'hC8CE, 16'h807F};
      do_reset();
      chk("model_cksum", cksum(28, 0), 'h9e3f);
      chk("model_wire", wire16('h001c), 'h1c00);

      capture = 1'b1;
      cap_q.delete();
      send_pkt(8, 1'b0);
      chk("t1_beats", cap_q.size(), 14);
      for (int i = 0; i < 10; i++) chk($sformatf("t1_hdr%0d", i), cap_q[i].d, lits[i]);
      chk("t1_start", cap_q[0].s, 1);
      chk("t1_term", cap_q[13].t, 1);
      chk("t1_noterm", cap_q[12].t, 0);

      cap_q.delete();
      send_pkt(8, 1'b0);
      chk("t1_next_id", cap_q[2].d, 16'h0100);

      cap_q.delete();
      send_pkt(3, 1'b0);
      chk("t3_tot", cap_q[1].d, 16'h1700);
      chk("t3_len0", cap_q[10].l, 2);
      chk("t3_len1", cap_q[11].l, 1);
      chk("t3_term0", cap_q[10].t, 0);
      chk("t3_term1", cap_q[11].t, 1);
      capture = 1'b0;

      rnd = 1'b1;
      repeat (25) send_pkt($urandom_range(1, 40), 1'b1);
      send_pkt(301, 1'b1);
      rnd = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      cancel_at(16, 4);
      send_pkt(5, 1'b0);
      cancel_at(2, 10);
      send_pkt(2, 1'b0);
      cancel_i = 1'b1;
      @(posedge clk); #1;
      cancel_i = 1'b0;

      send_drop(0);
      send_drop(65516);
      send_pkt(1, 1'b0);

      begin
         logic [15:0] pd[$];
         begin_pkt(20, pd);
         repeat (5) begin @(posedge clk); #1; end
         do_reset();
      end
      capture = 1'b1;
      cap_q.delete();
      send_pkt(4, 1'b0);
      chk("rst_mid_id", cap_q[2].d, 16'h0000);
      capture = 1'b0;

      do_reset();
      for (int i = 0; i < 65536; i++) begin
         if (i < 3 || i > 65532 || (i % 2048) == 0) send_pkt(1, 1'b0);
         else cancel_at(1, 0);
      end
      capture = 1'b1;
      cap_q.delete();
      send_pkt(1, 1'b0);
      chk("wrap_id", cap_q[2].d, 16'h0000);
      chk("wrap_cksum", cap_q[5].d, 16'h469E);
      capture = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
